// File: rtl/cart_input_conditioner.sv
// Input front end for the railway cart: synchronises and debounces the four raw board inputs,
// turns button presses into one-cycle pulses and paces auto mode with a periodic STEP strobe.
module cart_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEB_W           = 20,
  parameter int STEP_DIV        = 50_000_000,
  parameter int STEP_W          = 26
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic BTN_RIGHT_RAW,
  input  logic BTN_LEFT_RAW,
  input  logic SW_DIR_RAW,
  input  logic SW_AUTO_RAW,
  output logic RIGHT,
  output logic LEFT,
  output logic DIR,
  output logic AUTO,
  output logic STEP
);

  // Bit 1 of the state is the accepted level q, so q comes straight from a flop.
  typedef enum logic [1:0] {
    IDLE_LO = 2'b00,
    WAIT_HI = 2'b01,
    IDLE_HI = 2'b10,
    WAIT_LO = 2'b11
  } deb_state_t;

  localparam int                NUM_IN    = 4;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);

  logic [NUM_IN-1:0] w_raw;
  logic [NUM_IN-1:0] w_sync;
  logic [NUM_IN-1:0] w_q;
  logic [NUM_IN-1:0] w_q_next;

  assign w_raw = {SW_AUTO_RAW, SW_DIR_RAW, BTN_LEFT_RAW, BTN_RIGHT_RAW};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IN; gi++) begin : g_in
      logic [SYNC_STAGES-1:0] r_sync;
      deb_state_t             r_state;
      deb_state_t             w_state_next;
      logic [DEB_W-1:0]       r_cnt;
      logic [DEB_W-1:0]       w_cnt_next;

      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_sync  <= '0;
          r_state <= IDLE_LO;
          r_cnt   <= '0;
        end else begin
          r_sync  <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
          r_state <= w_state_next;
          r_cnt   <= w_cnt_next;
        end
      end

      // The cycle that leaves IDLE counts as the first stable sample, so a new level
      // is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
      always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
          IDLE_LO: begin
            if (w_sync[gi]) begin
              if (DEB_LAST == '0) begin
                w_state_next = IDLE_HI;
                w_cnt_next   = '0;
              end else begin
                w_state_next = WAIT_HI;
                w_cnt_next   = DEB_W'(1);
              end
            end
          end
          WAIT_HI: begin
            if (!w_sync[gi]) begin
              w_state_next = IDLE_LO;
              w_cnt_next   = '0;
            end else if (r_cnt == DEB_LAST) begin
              w_state_next = IDLE_HI;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + DEB_W'(1);
            end
          end
          IDLE_HI: begin
            if (!w_sync[gi]) begin
              if (DEB_LAST == '0) begin
                w_state_next = IDLE_LO;
                w_cnt_next   = '0;
              end else begin
                w_state_next = WAIT_LO;
                w_cnt_next   = DEB_W'(1);
              end
            end
          end
          WAIT_LO: begin
            if (w_sync[gi]) begin
              w_state_next = IDLE_HI;
              w_cnt_next   = '0;
            end else if (r_cnt == DEB_LAST) begin
              w_state_next = IDLE_LO;
              w_cnt_next   = '0;
            end else begin
              w_cnt_next = r_cnt + DEB_W'(1);
            end
          end
          default: begin
            w_state_next = IDLE_LO;
            w_cnt_next   = '0;
          end
        endcase
      end

      assign w_sync[gi]   = r_sync[SYNC_STAGES-1];
      assign w_q[gi]      = r_state[1];
      assign w_q_next[gi] = w_state_next[1];
    end
  endgenerate

  logic              r_right;
  logic              r_left;
  logic              r_step;
  logic [STEP_W-1:0] r_step_cnt;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_right <= 1'b0;
      r_left  <= 1'b0;
    end else begin
      r_right <= w_q_next[0] & ~w_q[0];
      r_left  <= w_q_next[1] & ~w_q[1];
    end
  end

  // Counting runs only while AUTO is high now and stays high, so the rising edge
  // starts from zero and the falling edge clears without a strobe.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_step_cnt <= '0;
      r_step     <= 1'b0;
    end else if (!w_q[3] || !w_q_next[3]) begin
      r_step_cnt <= '0;
      r_step     <= 1'b0;
    end else if (r_step_cnt == STEP_LAST) begin
      r_step_cnt <= '0;
      r_step     <= 1'b1;
    end else begin
      r_step_cnt <= r_step_cnt + STEP_W'(1);
      r_step     <= 1'b0;
    end
  end

  assign RIGHT = r_right;
  assign LEFT  = r_left;
  assign DIR   = w_q[2];
  assign AUTO  = w_q[3];
  assign STEP  = r_step;

endmodule

// File: tb/tb_cart_input_conditioner.sv
// Self-checking bench for cart_input_conditioner: directed scenarios plus random input
// activity, compared every cycle against a sliding-window debounce model.
module tb_cart_input_conditioner;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int SDIV = 8;

  logic CLK = 1'b0;
  logic RESET_N = 1'b1;
  logic BTN_RIGHT_RAW = 1'b0;
  logic BTN_LEFT_RAW = 1'b0;
  logic SW_DIR_RAW = 1'b0;
  logic SW_AUTO_RAW = 1'b0;
  logic RIGHT, LEFT, DIR, AUTO, STEP;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLK = ~CLK;

  cart_input_conditioner #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB),
    .DEB_W           (4),
    .STEP_DIV        (SDIV),
    .STEP_W          (4)
  ) dut (
    .CLK           (CLK),
    .RESET_N       (RESET_N),
    .BTN_RIGHT_RAW (BTN_RIGHT_RAW),
    .BTN_LEFT_RAW  (BTN_LEFT_RAW),
    .SW_DIR_RAW    (SW_DIR_RAW),
    .SW_AUTO_RAW   (SW_AUTO_RAW),
    .RIGHT         (RIGHT),
    .LEFT          (LEFT),
    .DIR           (DIR),
    .AUTO          (AUTO),
    .STEP          (STEP)
  );

  // Reference model: a level flips once the last DEB synchronised samples all
  // disagree with it; STEP fires every SDIV edges of continuous AUTO.
  logic       hist [4][$];
  logic       mq [4];
  int         n_auto;
  logic [4:0] exp_vec;

  initial begin : model
    logic raw [4];
    logic old_q [4];
    logic hit;
    logic smp;
    int   idx;
    for (int i = 0; i < 4; i++) mq[i] = 1'b0;
    n_auto  = 0;
    exp_vec = '0;
    forever begin
      @(posedge CLK or negedge RESET_N);
      if (!RESET_N) begin
        for (int i = 0; i < 4; i++) begin
          hist[i].delete();
          mq[i] = 1'b0;
        end
        n_auto  = 0;
        exp_vec = '0;
      end else begin
        raw[0] = BTN_RIGHT_RAW;
        raw[1] = BTN_LEFT_RAW;
        raw[2] = SW_DIR_RAW;
        raw[3] = SW_AUTO_RAW;
        for (int i = 0; i < 4; i++) begin
          old_q[i] = mq[i];
          hist[i].push_back(raw[i]);
          if (hist[i].size() > 32) void'(hist[i].pop_front());
          hit = 1'b1;
          for (int j = SYNC; j < SYNC + DEB; j++) begin
            idx = hist[i].size() - 1 - j;
            smp = (idx >= 0) ? hist[i][idx] : 1'b0;
            if (smp == mq[i]) hit = 1'b0;
          end
          if (hit) mq[i] = ~mq[i];
        end
        if (mq[3] && old_q[3]) n_auto++;
        else n_auto = 0;
        exp_vec = {mq[0] & ~old_q[0], mq[1] & ~old_q[1], mq[2], mq[3],
                   (mq[3] && old_q[3] && (n_auto % SDIV == 0))};
      end
    end
  end

  task automatic settle(input int n);
    BTN_RIGHT_RAW = 1'b0;
    BTN_LEFT_RAW  = 1'b0;
    SW_DIR_RAW    = 1'b0;
    SW_AUTO_RAW   = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({RIGHT, LEFT, DIR, AUTO, STEP} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_initial: got %b expected 00000", {RIGHT, LEFT, DIR, AUTO, STEP});
    end
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    SW_DIR_RAW  = 1'b1;
    SW_AUTO_RAW = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL reset_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
    end
    n_checks++;
    if ({DIR, AUTO} !== 2'b11) begin
      n_fails++;
      $display("FAIL reset_levels_up: got DIR/AUTO %b expected 11", {DIR, AUTO});
    end
    #2 RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({RIGHT, LEFT, DIR, AUTO, STEP} !== 5'b0) begin
      n_fails++;
      $display("FAIL reset_async: got %b expected 00000", {RIGHT, LEFT, DIR, AUTO, STEP});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    settle(10);
  endtask

  task automatic test_clean_press();
    int first = -1, pulses = 0, rel_pulses = 0;
    logic left_seen = 1'b0;
    BTN_RIGHT_RAW = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL press_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (RIGHT) begin
        pulses++;
        if (first < 0) first = e;
      end
      if (LEFT) left_seen = 1'b1;
    end
    BTN_RIGHT_RAW = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge CLK);
      if (RIGHT) rel_pulses++;
      if (LEFT) left_seen = 1'b1;
    end
    n_checks++;
    if (first != 6) begin n_fails++; $display("FAIL press_latency: got edge %0d expected 6", first); end
    n_checks++;
    if (pulses != 1) begin n_fails++; $display("FAIL press_count: got %0d pulses expected 1", pulses); end
    n_checks++;
    if (rel_pulses != 0) begin n_fails++; $display("FAIL press_release: got %0d pulses expected 0", rel_pulses); end
    n_checks++;
    if (left_seen !== 1'b0) begin n_fails++; $display("FAIL press_left_quiet: got LEFT seen %b expected 0", left_seen); end
  endtask

  task automatic test_bounce();
    int first = -1, pulses = 0;
    for (int seg = 0; seg < 6; seg++) begin
      BTN_LEFT_RAW = (seg % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        @(negedge CLK);
        n_checks++;
        if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
          n_fails++;
          $display("FAIL bounce_model seg %0d: got %b expected %b", seg, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
        end
        if (LEFT) pulses++;
      end
    end
    BTN_LEFT_RAW = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL bounce_model hold edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (LEFT) begin
        pulses++;
        if (first < 0) first = e;
      end
    end
    n_checks++;
    if (first != 6) begin n_fails++; $display("FAIL bounce_latency: got edge %0d expected 6", first); end
    n_checks++;
    if (pulses != 1) begin n_fails++; $display("FAIL bounce_count: got %0d pulses expected 1", pulses); end
    settle(12);
  endtask

  task automatic test_glitch();
    int first = -1;
    logic glitch_seen = 1'b0, dropped = 1'b0;
    SW_DIR_RAW = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(negedge CLK);
      if (e == 3) SW_DIR_RAW = 1'b0;
      if (DIR) glitch_seen = 1'b1;
    end
    n_checks++;
    if (glitch_seen !== 1'b0) begin n_fails++; $display("FAIL glitch_reject: got DIR seen %b expected 0", glitch_seen); end
    SW_DIR_RAW = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL glitch_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (DIR && first < 0) first = e;
      if (first > 0 && !DIR) dropped = 1'b1;
    end
    n_checks++;
    if (first != 6) begin n_fails++; $display("FAIL glitch_latency: got edge %0d expected 6", first); end
    n_checks++;
    if (dropped !== 1'b0) begin n_fails++; $display("FAIL glitch_hold: got DIR dropped %b expected 0", dropped); end
    settle(12);
  endtask

  task automatic test_auto();
    int rise = -1, fall = -1, late_steps = 0;
    int steps [$];
    SW_AUTO_RAW = 1'b1;
    for (int e = 1; e <= 35; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL auto_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (AUTO && rise < 0) rise = e;
      if (STEP) steps.push_back(e - rise);
    end
    n_checks++;
    if (rise != 6) begin n_fails++; $display("FAIL auto_rise: got edge %0d expected 6", rise); end
    n_checks++;
    if (steps.size() != 3 || steps[0] != 8 || steps[1] != 16 || steps[2] != 24) begin
      n_fails++;
      $display("FAIL auto_steps: got %0d steps at offsets %p expected 3 at 8,16,24", steps.size(), steps);
    end
    SW_AUTO_RAW = 1'b0;
    for (int e = 1; e <= 25; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL auto_fall_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (!AUTO && fall < 0) fall = e;
      if (fall > 0 && STEP) late_steps++;
    end
    n_checks++;
    if (fall != 6) begin n_fails++; $display("FAIL auto_fall: got edge %0d expected 6", fall); end
    n_checks++;
    if (late_steps != 0) begin n_fails++; $display("FAIL auto_no_step: got %0d steps after fall expected 0", late_steps); end
  endtask

  task automatic test_simultaneous();
    int fr = -1, fl = -1, pr = 0, pl = 0;
    BTN_RIGHT_RAW = 1'b1;
    BTN_LEFT_RAW  = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge CLK);
      if (RIGHT && fr < 0) fr = e;
      if (LEFT && fl < 0) fl = e;
    end
    n_checks++;
    if (fr != 6 || fl != 6) begin
      n_fails++;
      $display("FAIL simul_pulse: got RIGHT edge %0d LEFT edge %0d expected 6 and 6", fr, fl);
    end
    settle(12);
    BTN_RIGHT_RAW = 1'b1;
    BTN_LEFT_RAW  = 1'b1;
    repeat (3) @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({RIGHT, LEFT, DIR, AUTO, STEP} !== 5'b0) begin
      n_fails++;
      $display("FAIL simul_reset: got %b expected 00000", {RIGHT, LEFT, DIR, AUTO, STEP});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    fr = -1;
    fl = -1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL simul_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (RIGHT) begin pr++; if (fr < 0) fr = e; end
      if (LEFT) begin pl++; if (fl < 0) fl = e; end
    end
    n_checks++;
    if (fr != 6 || fl != 6 || pr != 1 || pl != 1) begin
      n_fails++;
      $display("FAIL simul_after_reset: got RIGHT %0d@%0d LEFT %0d@%0d expected 1@6 and 1@6", pr, fr, pl, fl);
    end
    settle(12);
  endtask

  task automatic test_random();
    int rp = 0, ap = 0;
    for (int e = 1; e <= 600; e++) begin
      if ($urandom_range(0, 5) == 0) BTN_RIGHT_RAW = ~BTN_RIGHT_RAW;
      if ($urandom_range(0, 5) == 0) BTN_LEFT_RAW  = ~BTN_LEFT_RAW;
      if ($urandom_range(0, 7) == 0) SW_DIR_RAW    = ~SW_DIR_RAW;
      if ($urandom_range(0, 29) == 0) SW_AUTO_RAW  = ~SW_AUTO_RAW;
      @(negedge CLK);
      n_checks++;
      if ({RIGHT, LEFT, DIR, AUTO, STEP} !== exp_vec) begin
        n_fails++;
        $display("FAIL random_model edge %0d: got %b expected %b", e, {RIGHT, LEFT, DIR, AUTO, STEP}, exp_vec);
      end
      if (RIGHT) rp++;
      if (STEP) ap++;
    end
    $display("random: %0d RIGHT pulses, %0d STEP strobes", rp, ap);
    settle(12);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_auto();
    test_simultaneous();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
